clk_period_meter: RTL and testbench

- Receive-side check for the divided clocks that feed the VFD PWM/sine stages.
- Samples a slow, nominally periodic signal (e.g. the 40.96 kHz-class divided clock) in the fast system clock domain.
- Measures the period between rising edges in clk_in cycles and declares lock when consecutive periods fall within tolerance of the expected value.
- Flags frequency error and loss of signal (timeout) so the drive can be inhibited.

---
 rtl/clk_meter_pkg.sv | 29 ++
 rtl/sync_edge_det.sv | 39 +++
 rtl/clk_period_meter.sv | 168 ++++++++++++++++
 tb/tb_clk_period_meter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : clk_meter_pkg                                                  |
// | Brief   : Shared types and default constants for the clock period meter  |
// |           and the divider configuration that produces the measured clock.|
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package clk_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } meter_state_t;

    // Defaults matching the divide-by-590 PWM/sine clock source
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_EXP_PERIOD = 590;
    localparam int unsigned DEF_TOL        = 4;
    localparam int unsigned DEF_LOCK_CNT   = 4;
    localparam int unsigned DEF_TIMEOUT    = 4096;

endpackage : clk_meter_pkg

`default_nettype wire

// File: rtl/sync_edge_det.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : sync_edge_det                                                  |
// | Brief   : Two-flop synchroniser followed by a history flop; flags a      |
// |           rising edge of an asynchronous input in the local clock domain.|
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module sync_edge_det (
    input  logic clk_in,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Metastability filter (s1, s2) plus one cycle of history (s3)
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule : sync_edge_det

`default_nettype wire

// File: rtl/clk_period_meter.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : clk_period_meter                                               |
// | Brief   : Measures the period of a slow asynchronous clock in clk_in     |
// |           cycles, declares lock after LOCK_CNT in-tolerance periods and  |
// |           flags frequency error and loss of signal.                      |
// |           Optional: CLK_PERIOD_METER_MINMAX_EN adds min/max period       |
// |           tracking while locked (period_min, period_max, minmax_clr).    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int unsigned TOL        = DEF_TOL,
    parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             freq_err,
    output logic             timeout
`ifdef CLK_PERIOD_METER_MINMAX_EN
    ,
    input  logic             minmax_clr,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
`endif
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  EXP_C        = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0]  TOL_C        = CNT_W'(TOL);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [GOOD_W-1:0] LOCK_C       = GOOD_W'(LOCK_CNT);

    meter_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good_cnt;

    logic              rise;
    logic [CNT_W-1:0]  meas;
    logic [CNT_W-1:0]  diff;
    logic              in_tol;
    logic [GOOD_W-1:0] next_good;

    sync_edge_det u_sync (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .async_in (sig_in),
        .rise     (rise)
    );

    // Period estimate and tolerance test; cnt never exceeds TIMEOUT-1 so cnt+1 fits
    always_comb begin
        meas      = cnt + 1'b1;
        diff      = (meas >= EXP_C) ? (meas - EXP_C) : (EXP_C - meas);
        in_tol    = (diff <= TOL_C);
        next_good = (good_cnt == LOCK_C) ? LOCK_C : (good_cnt + 1'b1);
    end

    // Measurement FSM with registered pulse and level outputs
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            freq_err     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            freq_err     <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    good_cnt <= '0;
                    locked   <= 1'b0;
                    // First edge only opens the measurement window
                    if (rise) begin
                        state <= ACQUIRE;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (rise) begin
                        // A rise wins over a coincident timeout
                        cnt          <= '0;
                        period_out   <= meas;
                        period_valid <= 1'b1;
                        if (in_tol) begin
                            good_cnt <= next_good;
                            if (next_good == LOCK_C) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            freq_err <= 1'b1;
                            good_cnt <= '0;
                            state    <= ACQUIRE;
                            locked   <= 1'b0;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout  <= 1'b1;
                        state    <= IDLE;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_PERIOD_METER_MINMAX_EN
    logic lock_entry;
    logic lock_update;

    // Classify the current measurement for the min/max trackers
    always_comb begin
        lock_entry  = rise && in_tol && (next_good == LOCK_C) && (state == ACQUIRE);
        lock_update = rise && in_tol && (state == LOCKED);
    end

    // Extremes of measured period while locked; clear reloads the published period
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            period_min <= '0;
            period_max <= '0;
        end else if (minmax_clr) begin
            period_min <= period_out;
            period_max <= period_out;
        end else if (lock_entry) begin
            period_min <= meas;
            period_max <= meas;
        end else if (lock_update) begin
            if (meas < period_min) begin
                period_min <= meas;
            end
            if (meas > period_max) begin
                period_max <= meas;
            end
        end
    end
`endif

endmodule : clk_period_meter

`default_nettype wire

// File: tb/tb_clk_period_meter.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : tb_clk_period_meter                                            |
// | Brief   : Self-checking bench for clk_period_meter. Edge schedule is     |
// |           known ahead of time; an event-level model predicts every       |
// |           output pulse and the cycle it appears in.                      |
// |           CLK_PERIOD_METER_MINMAX_EN also exercises min/max tracking.    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_period_meter;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned EXP      = 590;
    localparam int unsigned TOL      = 4;
    localparam int unsigned LOCK     = 4;
    localparam int unsigned TIMEOUT  = 4096;
    // sig_in change -> s1 -> s2 -> registered outputs
    localparam int unsigned LATENCY  = 3;

    logic             clk_in;
    logic             reset_n;
    logic             sig_in;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             freq_err;
    logic             timeout;
`ifdef CLK_PERIOD_METER_MINMAX_EN
    logic             minmax_clr;
    logic [CNT_W-1:0] period_min;
    logic [CNT_W-1:0] period_max;
`endif

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP),
        .TOL        (TOL),
        .LOCK_CNT   (LOCK),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .freq_err     (freq_err),
        .timeout      (timeout)
`ifdef CLK_PERIOD_METER_MINMAX_EN
        ,
        .minmax_clr   (minmax_clr),
        .period_min   (period_min),
        .period_max   (period_max)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Number of rising clk_in edges seen so far
    int unsigned cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned cyc;
        logic        valid;
        int unsigned period;
        logic        ferr;
        logic        lck;
        logic        tout;
    } ev_t;

    ev_t         exp_q[$];
    bit          m_idle   = 1'b1;
    int unsigned m_good   = 0;
    bit          m_lock   = 1'b0;
    int unsigned m_last   = 0;
    int unsigned m_period = 0;

    // A rise driven at cycle c, next rise scheduled n cycles later
    task automatic model_rise(input int unsigned c, input int unsigned n);
        int unsigned p;
        int unsigned dev;
        bit          bad;
        if (m_idle) begin
            m_idle = 1'b0;
            m_good = 0;
        end else begin
            p   = c - m_last;
            dev = (p > EXP) ? p - EXP : EXP - p;
            bad = (dev > TOL);
            if (bad) m_good = 0;
            else if (m_good < LOCK) m_good++;
            m_lock   = (m_good == LOCK);
            m_period = p;
            exp_q.push_back('{c + LATENCY, 1'b1, p, bad, m_lock, 1'b0});
        end
        m_last = c;
        if (n > TIMEOUT) begin
            exp_q.push_back('{c + LATENCY + TIMEOUT, 1'b0, m_period, 1'b0, 1'b0, 1'b1});
            m_idle = 1'b1;
            m_lock = 1'b0;
            m_good = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_idle   = 1'b1;
        m_good   = 0;
        m_lock   = 1'b0;
        m_period = 0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        ev_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check_eq("period_valid", {31'd0, period_valid}, {31'd0, e.valid});
            check_eq("freq_err",     {31'd0, freq_err},     {31'd0, e.ferr});
            check_eq("timeout",      {31'd0, timeout},      {31'd0, e.tout});
            check_eq("locked",       {31'd0, locked},       {31'd0, e.lck});
            check_eq("period_out",   {16'd0, period_out},   e.period);
        end else if (period_valid || freq_err || timeout) begin
            check_eq("spurious_pulse", {29'd0, period_valid, freq_err, timeout}, 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    // One period of n cycles: rise now, high n/2 cycles, low the rest
    task automatic gen_period(input int unsigned n);
        @(negedge clk_in);
        sig_in = 1'b1;
        model_rise(cyc, n);
        repeat (n / 2) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (n - n / 2 - 1) @(negedge clk_in);
    endtask

    task automatic gen_n(input int unsigned n, input int unsigned count);
        for (int i = 0; i < count; i++) gen_period(n);
    endtask

    initial begin
        reset_n = 1'b0;
        sig_in  = 1'b0;
`ifdef CLK_PERIOD_METER_MINMAX_EN
        minmax_clr = 1'b0;
`endif
        repeat (4) @(negedge clk_in);
        check_eq("rst_period_out",   {16'd0, period_out},   32'd0);
        check_eq("rst_period_valid", {31'd0, period_valid}, 32'd0);
        check_eq("rst_locked",       {31'd0, locked},       32'd0);
        check_eq("rst_freq_err",     {31'd0, freq_err},     32'd0);
        check_eq("rst_timeout",      {31'd0, timeout},      32'd0);
        reset_n = 1'b1;

        // Nominal frequency: lock on the 4th published period
        gen_n(EXP, 8);

        // Edge-of-tolerance jitter, then one period just outside, then relock
        for (int i = 0; i < 10; i++) gen_period((i % 2 == 0) ? EXP + TOL : EXP - TOL);
        gen_period(EXP + TOL + 1);
        gen_n(EXP, 6);

`ifdef CLK_PERIOD_METER_MINMAX_EN
        gen_period(588);
        gen_period(593);
        gen_period(EXP);
        repeat (8) @(negedge clk_in);
        check_eq("period_min", {16'd0, period_min}, 32'd588);
        check_eq("period_max", {16'd0, period_max}, 32'd593);
        minmax_clr = 1'b1;
        @(negedge clk_in);
        minmax_clr = 1'b0;
        check_eq("min_after_clr", {16'd0, period_min}, m_period);
        check_eq("max_after_clr", {16'd0, period_max}, m_period);
`endif

        // Random periods around nominal, in and out of tolerance
        for (int i = 0; i < 20; i++) gen_period($urandom_range(EXP + 12, EXP - 12));

        // Lock, then lose the signal; resume afterwards
        gen_n(EXP, 5);
        gen_period(TIMEOUT + 104);
        gen_n(EXP, 6);

        // Rise coincident with the last count before timeout
        gen_period(TIMEOUT);
        gen_n(EXP, 6);

        // Asynchronous reset mid-period while locked
        repeat (100) @(negedge clk_in);
        check_eq("locked_before_reset", {31'd0, locked}, {31'd0, m_lock});
        @(posedge clk_in);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_period_out", {16'd0, period_out},   32'd0);
        check_eq("async_locked",     {31'd0, locked},       32'd0);
        check_eq("async_valid",      {31'd0, period_valid}, 32'd0);
        model_reset();
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        gen_n(EXP, 6);

        repeat (10) @(negedge clk_in);
        check_eq("events_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clk_period_meter

`default_nettype wire
